// File: rtl/array_min_normalizer.sv
// Serial minimum search over a packed cost array, then subtraction of that minimum from every element.
// Optional early exit on a zero element is enabled by defining ARRMIN_ZERO_EXIT_EN.
module array_min_normalizer #(
    parameter  int dataW = 8,
    parameter  int ArrL  = 8,
    localparam int IdxW  = $clog2(ArrL) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [dataW*ArrL-1:0] in_arr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dataW*ArrL-1:0] out_arr,
    output logic [dataW-1:0]      out_min,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SUB  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                  state_r;
    logic [dataW*ArrL-1:0]   arr_r;
    logic [dataW-1:0]        min_r;
    logic [IdxW-1:0]         idx_r;
    logic [dataW-1:0]        in_elem0_s;
    logic [dataW-1:0]        cur_elem_s;
    logic [dataW-1:0]        scan_min_s;
    logic                    scan_last_s;

    // Array add/sub datapath in subtract mode: every element minus a common value.
    function automatic logic [dataW*ArrL-1:0] sub_array(
        input logic [dataW*ArrL-1:0] arr,
        input logic [dataW-1:0]      value
    );
        logic [dataW*ArrL-1:0] res;
        res = {(dataW*ArrL){1'b0}};
        for (int i = 0; i < ArrL; i++) begin
            res[i*dataW +: dataW] = arr[i*dataW +: dataW] - value;
        end
        return res;
    endfunction

    assign in_elem0_s  = in_arr[dataW-1:0];
    assign scan_min_s  = (cur_elem_s < min_r) ? cur_elem_s : min_r;
    assign scan_last_s = (idx_r == IdxW'(ArrL - 1));

    // Element selected by the scan index; a one-hot style mux avoids an out-of-range index.
    always_comb begin
        cur_elem_s = {dataW{1'b0}};
        for (int i = 0; i < ArrL; i++) begin
            cur_elem_s = (idx_r == IdxW'(i)) ? arr_r[i*dataW +: dataW] : cur_elem_s;
        end
    end

    // Sequencer FSM with all handshake and result outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            arr_r     <= {(dataW*ArrL){1'b0}};
            min_r     <= {dataW{1'b0}};
            idx_r     <= {IdxW{1'b0}};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_arr   <= {(dataW*ArrL){1'b0}};
            out_min   <= {dataW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        arr_r    <= in_arr;
                        min_r    <= in_elem0_s;
                        idx_r    <= IdxW'(1);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef ARRMIN_ZERO_EXIT_EN
                        if (in_elem0_s == {dataW{1'b0}}) begin
                            out_arr   <= in_arr;
                            out_min   <= {dataW{1'b0}};
                            out_valid <= 1'b1;
                            state_r   <= HOLD;
                        end else begin
                            state_r <= (ArrL == 1) ? SUB : SCAN;
                        end
`else
                        state_r <= (ArrL == 1) ? SUB : SCAN;
`endif
                    end
                end
                SCAN: begin
                    min_r <= scan_min_s;
                    idx_r <= idx_r + IdxW'(1);
`ifdef ARRMIN_ZERO_EXIT_EN
                    // A zero element already is the minimum, so the array passes through unchanged.
                    if (cur_elem_s == {dataW{1'b0}}) begin
                        out_arr   <= arr_r;
                        out_min   <= {dataW{1'b0}};
                        out_valid <= 1'b1;
                        state_r   <= HOLD;
                    end else if (scan_last_s) begin
                        state_r <= SUB;
                    end
`else
                    if (scan_last_s) begin
                        state_r <= SUB;
                    end
`endif
                end
                SUB: begin
                    out_arr   <= sub_array(arr_r, min_r);
                    out_min   <= min_r;
                    out_valid <= 1'b1;
                    state_r   <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_min_normalizer.sv
// Scoreboard bench for array_min_normalizer: an ArrL=8 instance plus an ArrL=1 instance.
// Expected latency follows ARRMIN_ZERO_EXIT_EN when the bench is built with it.
module tb_array_min_normalizer;

    typedef struct {
        logic [7:0]  mn;
        logic [63:0] arr;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_arr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_arr;
    logic [7:0]  out_min;
    logic        busy;

    logic        in1_valid;
    logic        in1_ready;
    logic [7:0]  in1_arr;
    logic        out1_valid;
    logic        out1_ready;
    logic [7:0]  out1_arr;
    logic [7:0]  out1_min;
    logic        busy1;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;
    int   cyc;

    array_min_normalizer #(.dataW(8), .ArrL(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_arr(in_arr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_arr(out_arr), .out_min(out_min), .busy(busy)
    );

    array_min_normalizer #(.dataW(8), .ArrL(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in1_valid), .in_ready(in1_ready), .in_arr(in1_arr),
        .out_valid(out1_valid), .out_ready(out1_ready),
        .out_arr(out1_arr), .out_min(out1_min), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter used to measure accept spacing.
    always_ff @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: minimum, normalized array and expected latency.
    task automatic push_expect(input logic [7:0] e [8], output logic [63:0] packed_arr);
        exp_t x;
        logic [7:0] mn;
        mn = e[0];
        x.lat = 8;
        for (int i = 0; i < 8; i++) begin
            packed_arr[i*8 +: 8] = e[i];
            if (e[i] < mn) mn = e[i];
        end
`ifdef ARRMIN_ZERO_EXIT_EN
        for (int i = 7; i >= 0; i--) begin
            if (e[i] == 8'd0) x.lat = i;
        end
`endif
        for (int i = 0; i < 8; i++) x.arr[i*8 +: 8] = e[i] - mn;
        x.mn = mn;
        exp_q.push_back(x);
    endtask

    task automatic wait_in_ready();
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        check_eq("in_ready_wait", {63'd0, in_ready}, 64'd1);
    endtask

    // Wait for out_valid counting edges since the accept edge, then compare against the scoreboard head.
    task automatic wait_and_compare(input string tag);
        int   n;
        exp_t x;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_nonempty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            x = exp_q.pop_front();
            check_eq({tag, "_lat"}, 64'(n), 64'(x.lat));
            check_eq({tag, "_min"}, {56'd0, out_min}, {56'd0, x.mn});
            check_eq({tag, "_arr"}, out_arr, x.arr);
        end
    endtask

    task automatic run_array(input string tag, input logic [7:0] e [8], input int hold);
        logic [63:0] a;
        out_ready = (hold == 0);
        wait_in_ready();
        push_expect(e, a);
        in_arr   = a;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, "_busy"}, {62'd0, busy, in_ready}, 64'd2);
        wait_and_compare(tag);
        for (int i = 0; i < hold; i++) begin
            logic [63:0] arr_snap;
            logic [7:0]  min_snap;
            arr_snap = out_arr;
            min_snap = out_min;
            in_valid = i[0];
            in_arr   = ~a;
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, {62'd0, out_valid, in_ready}, 64'd2);
            check_eq({tag, "_hold_arr"}, out_arr, arr_snap);
            check_eq({tag, "_hold_min"}, {56'd0, out_min}, {56'd0, min_snap});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, "_release"}, {61'd0, out_valid, in_ready, busy}, 64'd2);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] prev;
        n_vec      = 0;
        n_err      = 0;
        cyc        = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_arr     = 64'd0;
        out_ready  = 1'b0;
        in1_valid  = 1'b0;
        in1_arr    = 8'd0;
        out1_ready = 1'b1;
        prev       = 64'd0;

        @(negedge clk);
        @(negedge clk);
        check_eq("rst_ctrl", {61'd0, out_valid, in_ready, busy}, 64'd2);
        check_eq("rst_arr", out_arr, 64'd0);
        check_eq("rst_min", {56'd0, out_min}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_array("mixed", '{8'd9, 8'd5, 8'd7, 8'd3, 8'd8, 8'd3, 8'd6, 8'd4}, 0);
        run_array("all255", '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255}, 0);
        run_array("all0", '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 0);
        run_array("zero_at2", '{8'd4, 8'd6, 8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd7}, 0);
        run_array("stall", '{8'd200, 8'd17, 8'd90, 8'd255, 8'd18, 8'd33, 8'd17, 8'd64}, 5);
        run_array("min_last", '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd1}, 0);

        // Reset in the middle of a scan: idx reaches 4 three edges after the accept.
        wait_in_ready();
        push_expect('{8'd9, 8'd5, 8'd7, 8'd3, 8'd8, 8'd3, 8'd6, 8'd4}, a);
        in_arr   = a;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_ctrl", {61'd0, out_valid, in_ready, busy}, 64'd2);
        check_eq("midrst_arr", out_arr, 64'd0);
        check_eq("midrst_min", {56'd0, out_min}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("midrst_no_output", {63'd0, out_valid}, 64'd0);
        run_array("after_rst", '{8'd33, 8'd44, 8'd22, 8'd99, 8'd23, 8'd22, 8'd100, 8'd250}, 0);

        // Back-to-back traffic: in_valid and out_ready held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            logic [7:0] e [8];
            for (int i = 0; i < 8; i++) e[i] = 8'((j * 37 + i * 13) % 200 + 1);
            wait_in_ready();
            push_expect(e, a);
            in_arr = a;
            if (j > 0) check_eq("b2b_interval", 64'(cyc) - prev, 64'd10);
            prev = 64'(cyc);
            @(negedge clk);
            wait_and_compare("b2b");
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Single-element instance: result is always zero and the minimum is the element itself.
        for (int j = 0; j < 2; j++) begin
            exp_t x;
            int   n;
            x.mn  = (j == 0) ? 8'd77 : 8'd0;
            x.arr = 64'd0;
`ifdef ARRMIN_ZERO_EXIT_EN
            x.lat = (j == 0) ? 1 : 0;
`else
            x.lat = 1;
`endif
            exp_q.push_back(x);
            for (int i = 0; i < 50 && !in1_ready; i++) @(negedge clk);
            in1_arr   = x.mn;
            in1_valid = 1'b1;
            @(negedge clk);
            in1_valid = 1'b0;
            n = 0;
            while (!out1_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            x = exp_q.pop_front();
            check_eq("arrl1_lat", 64'(n), 64'(x.lat));
            check_eq("arrl1_min", {56'd0, out1_min}, {56'd0, x.mn});
            check_eq("arrl1_arr", {56'd0, out1_arr}, x.arr);
            @(negedge clk);
        end

        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
